board_io_ctrl: RTL and testbench

- Parametrised board-level LED/button controller between the Murax GPIO/APB side and iCEBreaker pins.
- Adds two things the direct GPIO-to-pin wiring lacks:
  - per-LED PWM dimming with glitch-free duty updates;
  - per-button synchronisation, debouncing and press/release event pulses.
- Sits in the toplevel next to the Murax instance; scales to any LED/button count on a board.

---
 rtl/board_io_ctrl.sv | 144 ++++++++++++++
 tb/tb_board_io_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board-level LED/button front end: PWM-dimmed LEDs with period-aligned duty updates,
// and synchronised, debounced buttons with press/release event pulses.
module board_io_ctrl #(
    parameter int LED_COUNT       = 2,
    parameter int BTN_COUNT       = 1,
    parameter int PWM_WIDTH       = 8,
    parameter int PRESCALE        = 47,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int LED_ACTIVE_LOW  = 1,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                                                  io_mainClk,
    input  logic                                                  io_reset,
    input  logic [LED_COUNT-1:0]                                  io_ledEnable,
    input  logic                                                  io_dutyWrite_valid,
    output logic                                                  io_dutyWrite_ready,
    input  logic [((LED_COUNT > 1) ? $clog2(LED_COUNT) : 1)-1:0]  io_dutyWrite_sel,
    input  logic [PWM_WIDTH-1:0]                                  io_dutyWrite_value,
    output logic [LED_COUNT-1:0]                                  io_leds,
    input  logic [BTN_COUNT-1:0]                                  io_buttons,
    output logic [BTN_COUNT-1:0]                                  io_btnLevel,
    output logic [BTN_COUNT-1:0]                                  io_btnPress,
    output logic [BTN_COUNT-1:0]                                  io_btnRelease
);

    localparam int SEL_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PRE_W-1:0]     PRE_LAST     = PRE_W'(PRESCALE - 1);
    localparam logic [DEB_W-1:0]     DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_WIDTH-1:0] DUTY_FULL    = {PWM_WIDTH{1'b1}};
    localparam logic [LED_COUNT-1:0] LEDS_OFF     = (LED_ACTIVE_LOW != 0) ? {LED_COUNT{1'b1}} : {LED_COUNT{1'b0}};
    localparam logic [BTN_COUNT-1:0] BTN_RELEASED = (BTN_ACTIVE_LOW != 0) ? {BTN_COUNT{1'b1}} : {BTN_COUNT{1'b0}};

    logic [PRE_W-1:0]     prescale;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic                 tick;
    logic                 boundary;
    logic                 write_fire;

    logic [PWM_WIDTH-1:0] active_duty [LED_COUNT];
    logic [PWM_WIDTH-1:0] shadow_duty [LED_COUNT];
    logic [LED_COUNT-1:0] pending;
    logic [LED_COUNT-1:0] lit;

    logic [BTN_COUNT-1:0] sync_a;
    logic [BTN_COUNT-1:0] sync_b;
    logic [BTN_COUNT-1:0] sampled;
    logic [BTN_COUNT-1:0] stable;
    logic [DEB_W-1:0]     deb_cnt [BTN_COUNT];

    assign tick       = (prescale == PRE_LAST);
    assign boundary   = tick && (pwm_cnt == DUTY_FULL);
    assign write_fire = io_dutyWrite_valid && io_dutyWrite_ready;

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            prescale           <= '0;
            pwm_cnt            <= '0;
            io_dutyWrite_ready <= 1'b0;
        end else begin
            io_dutyWrite_ready <= 1'b1;
            if (tick) begin
                prescale <= '0;
                pwm_cnt  <= pwm_cnt + PWM_WIDTH'(1);
            end else begin
                prescale <= prescale + PRE_W'(1);
            end
        end
    end

    // A write landing on the boundary cycle must stay pending, so it is applied after the transfer.
    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            for (int i = 0; i < LED_COUNT; i++) begin
                active_duty[i] <= DUTY_FULL;
                shadow_duty[i] <= DUTY_FULL;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < LED_COUNT; i++) begin
                if (boundary && pending[i]) begin
                    active_duty[i] <= shadow_duty[i];
                    pending[i]     <= 1'b0;
                end
                if (write_fire && (io_dutyWrite_sel == SEL_W'(i))) begin
                    shadow_duty[i] <= io_dutyWrite_value;
                    pending[i]     <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        lit = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            lit[i] = io_ledEnable[i] && ((active_duty[i] == DUTY_FULL) || (pwm_cnt < active_duty[i]));
        end
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            io_leds <= LEDS_OFF;
        end else begin
            io_leds <= (LED_ACTIVE_LOW != 0) ? ~lit : lit;
        end
    end

    // The synchroniser resets to the released pin level so a held button reads as a fresh press.
    assign sampled     = (BTN_ACTIVE_LOW != 0) ? ~sync_b : sync_b;
    assign io_btnLevel = stable;

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            sync_a        <= BTN_RELEASED;
            sync_b        <= BTN_RELEASED;
            stable        <= '0;
            io_btnPress   <= '0;
            io_btnRelease <= '0;
            for (int b = 0; b < BTN_COUNT; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            sync_a <= io_buttons;
            sync_b <= sync_a;
            for (int b = 0; b < BTN_COUNT; b++) begin
                io_btnPress[b]   <= 1'b0;
                io_btnRelease[b] <= 1'b0;
                if (sampled[b] == stable[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_LAST) begin
                    stable[b]        <= sampled[b];
                    deb_cnt[b]       <= '0;
                    io_btnPress[b]   <= sampled[b];
                    io_btnRelease[b] <= ~sampled[b];
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: a time-based reference model queues expected outputs per cycle,
// and aggregate lit-cycle / event counts are checked against the intended duty and debounce behaviour.
module tb_board_io_ctrl;

    localparam int PWM_W  = 4;
    localparam int PRE    = 2;
    localparam int DEB    = 4;
    localparam int PERIOD = PRE * (1 << PWM_W);

    typedef struct packed {
        logic [1:0] leds;
        logic [2:0] leds3;
        logic [1:0] level;
        logic [1:0] press;
        logic [1:0] rel;
        logic       ready;
        logic       measure;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [1:0] led_en;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_sel;
    logic [3:0] wr_value;
    logic [1:0] leds;
    logic [1:0] buttons;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;

    logic       wr3_valid;
    logic       wr3_ready;
    logic [1:0] wr3_sel;
    logic [3:0] wr3_value;
    logic [2:0] led3_en;
    logic [2:0] leds3;
    logic [1:0] level3;
    logic [1:0] press3;
    logic [1:0] release3;

    board_io_ctrl #(
        .LED_COUNT(2), .BTN_COUNT(2), .PWM_WIDTH(PWM_W), .PRESCALE(PRE),
        .DEBOUNCE_CYCLES(DEB), .LED_ACTIVE_LOW(1), .BTN_ACTIVE_LOW(1)
    ) u_dut (
        .io_mainClk(clk), .io_reset(rst_in), .io_ledEnable(led_en),
        .io_dutyWrite_valid(wr_valid), .io_dutyWrite_ready(wr_ready),
        .io_dutyWrite_sel(wr_sel), .io_dutyWrite_value(wr_value),
        .io_leds(leds), .io_buttons(buttons), .io_btnLevel(btn_level),
        .io_btnPress(btn_press), .io_btnRelease(btn_release)
    );

    // Three-LED instance so an out-of-range select is representable on the 2-bit select port.
    board_io_ctrl #(
        .LED_COUNT(3), .BTN_COUNT(2), .PWM_WIDTH(PWM_W), .PRESCALE(PRE),
        .DEBOUNCE_CYCLES(DEB), .LED_ACTIVE_LOW(1), .BTN_ACTIVE_LOW(1)
    ) u_dut3 (
        .io_mainClk(clk), .io_reset(rst_in), .io_ledEnable(led3_en),
        .io_dutyWrite_valid(wr3_valid), .io_dutyWrite_ready(wr3_ready),
        .io_dutyWrite_sel(wr3_sel), .io_dutyWrite_value(wr3_value),
        .io_leds(leds3), .io_buttons(buttons), .io_btnLevel(level3),
        .io_btnPress(press3), .io_btnRelease(release3)
    );

    always #5 clk = ~clk;

    exp_t sb_queue[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cycle_idx    = 0;
    logic measure_on   = 1'b0;
    logic [1:0] en_hold;
    logic [1:0] btn_hold;

    int lit_cnt0, lit_cnt1;
    int press_cnt0, press_cnt1, rel_cnt0, rel_cnt1, rel_both;
    int press_idx, final_idx, rst_idx;

    int         m_t;
    logic       m_ready;
    logic [3:0] m_active [2];
    logic [3:0] m_shadow [2];
    logic [1:0] m_pending;
    logic [1:0] m_s1, m_s2, m_stable;
    int         m_run [2];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle_idx);
        end
    endtask

    task automatic popAndCompare();
        exp_t e;
        e = sb_queue.pop_front();
        checkOutput("leds", 32'(leds), 32'(e.leds));
        checkOutput("leds3", 32'(leds3), 32'(e.leds3));
        checkOutput("btn_level", 32'(btn_level), 32'(e.level));
        checkOutput("btn_press", 32'(btn_press), 32'(e.press));
        checkOutput("btn_release", 32'(btn_release), 32'(e.rel));
        checkOutput("write_ready", 32'(wr_ready), 32'(e.ready));
        if (e.measure) begin
            lit_cnt0 += (leds[0] === 1'b0) ? 1 : 0;
            lit_cnt1 += (leds[1] === 1'b0) ? 1 : 0;
        end
        if (btn_press[0] === 1'b1) begin
            press_cnt0++;
            press_idx = cycle_idx;
        end
        if (btn_press[1] === 1'b1) press_cnt1++;
        if (btn_release[0] === 1'b1) rel_cnt0++;
        if (btn_release[1] === 1'b1) rel_cnt1++;
        if (btn_release === 2'b11) rel_both++;
    endtask

    // Drives one cycle of stimulus and queues what the outputs must show after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic wv, input logic sel,
                                 input logic [3:0] val, input logic wv3);
        exp_t       e;
        logic [1:0] smp;
        int         cnt_m;
        logic       lit;
        @(negedge clk);
        if (sb_queue.size() > 0) popAndCompare();
        rst_in    = rst;
        wr_valid  = wv;
        wr_sel    = sel;
        wr_value  = val;
        wr3_valid = wv3;
        led_en    = en_hold;
        buttons   = btn_hold;
        e = '0;
        if (rst) begin
            e.leds  = 2'b11;
            e.leds3 = 3'b111;
            m_t = 0;
            m_ready = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 4'hF;
                m_shadow[i] = 4'hF;
                m_run[i]    = 0;
            end
            m_pending = 2'b00;
            m_s1 = 2'b11;
            m_s2 = 2'b11;
            m_stable = 2'b00;
        end else begin
            cnt_m = (m_t / PRE) % (1 << PWM_W);
            for (int i = 0; i < 2; i++) begin
                lit = en_hold[i] && ((m_active[i] == 4'hF) || (cnt_m < int'(m_active[i])));
                e.leds[i] = ~lit;
            end
            e.leds3 = 3'b000;
            if ((m_t % PERIOD) == PERIOD - 1) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_pending[i]) begin
                        m_active[i]  = m_shadow[i];
                        m_pending[i] = 1'b0;
                    end
                end
            end
            if (wv && m_ready) begin
                m_shadow[sel]  = val;
                m_pending[sel] = 1'b1;
            end
            m_t++;
            m_ready = 1'b1;
            smp = ~m_s2;
            for (int b = 0; b < 2; b++) begin
                if (smp[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_stable[b] = smp[b];
                        m_run[b]    = 0;
                        if (smp[b]) e.press[b] = 1'b1;
                        else        e.rel[b]   = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            e.level = m_stable;
            m_s2 = m_s1;
            m_s1 = btn_hold;
            e.ready = 1'b1;
        end
        e.measure = measure_on;
        sb_queue.push_back(e);
        cycle_idx++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic idleUntilPhase(input int phase);
        while ((m_t % PERIOD) != phase) idle(1);
    endtask

    task automatic measureCycles(input int n);
        lit_cnt0 = 0;
        lit_cnt1 = 0;
        measure_on = 1'b1;
        idle(n);
        measure_on = 1'b0;
        idle(1);
    endtask

    task automatic clearEvents();
        press_cnt0 = 0; press_cnt1 = 0; rel_cnt0 = 0; rel_cnt1 = 0; rel_both = 0; press_idx = -1;
    endtask

    task automatic drainQueue();
        @(negedge clk);
        while (sb_queue.size() > 0) popAndCompare();
    endtask

    initial begin
        rst_in = 1'b1; led_en = 2'b00; wr_valid = 1'b0; wr_sel = 1'b0; wr_value = 4'd0;
        wr3_valid = 1'b0; wr3_sel = 2'd3; wr3_value = 4'd0; led3_en = 3'b111; buttons = 2'b11;
        en_hold = 2'b11; btn_hold = 2'b11;
        clearEvents();

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Default duty is full: both LEDs lit for two whole periods.
        measureCycles(2 * PERIOD);
        checkOutput("idle_led0_lit", 32'(lit_cnt0), 32'd64);
        checkOutput("idle_led1_lit", 32'(lit_cnt1), 32'd64);

        // Mid-period write takes effect only from the next period.
        idleUntilPhase(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd4, 1'b0);
        idleUntilPhase(0);
        measureCycles(PERIOD);
        checkOutput("duty4_led0_lit", 32'(lit_cnt0), 32'd8);
        checkOutput("duty4_led1_lit", 32'(lit_cnt1), 32'd32);

        // Last write in a period wins; out-of-range select on the 3-LED instance is ignored.
        idleUntilPhase(5);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
        idle(4);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
        idleUntilPhase(0);
        measureCycles(PERIOD);
        checkOutput("duty9_led0_lit", 32'(lit_cnt0), 32'd8);
        checkOutput("duty9_led1_lit", 32'(lit_cnt1), 32'd18);

        // Bouncy press on BTN0: short pulses are rejected, one press after the final edge.
        clearEvents();
        btn_hold = 2'b10; idle(3);
        btn_hold = 2'b11; idle(3);
        btn_hold = 2'b10; idle(3);
        btn_hold = 2'b11; idle(2);
        btn_hold = 2'b10;
        final_idx = cycle_idx;
        idle(12);
        checkOutput("bounce_press0_count", 32'(press_cnt0), 32'd1);
        checkOutput("bounce_press1_count", 32'(press_cnt1), 32'd0);
        checkOutput("bounce_release_count", 32'(rel_cnt0 + rel_cnt1), 32'd0);
        checkOutput("bounce_press_latency", 32'(press_idx - final_idx), 32'd6);
        checkOutput("bounce_level", 32'(btn_level), 32'h1);

        // Simultaneous release of both buttons.
        btn_hold = 2'b00; idle(12);
        clearEvents();
        btn_hold = 2'b11; idle(12);
        checkOutput("release_both_cycles", 32'(rel_both), 32'd1);
        checkOutput("release0_count", 32'(rel_cnt0), 32'd1);
        checkOutput("release1_count", 32'(rel_cnt1), 32'd1);
        checkOutput("release_level", 32'(btn_level), 32'h0);

        // Reset with a pending duty write and a held button.
        btn_hold = 2'b10; idle(10);
        idleUntilPhase(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        idle(2);
        clearEvents();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        rst_idx = cycle_idx;
        measureCycles(2 * PERIOD);
        checkOutput("reset_press_latency", 32'(press_idx - rst_idx), 32'd6);
        checkOutput("reset_press_count", 32'(press_cnt0), 32'd1);
        checkOutput("reset_led0_lit", 32'(lit_cnt0), 32'd64);
        checkOutput("reset_led1_lit", 32'(lit_cnt1), 32'd64);

        drainQueue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
